// File: rtl/board_scanner.sv
// Tic-tac-toe board scanner: reads the 9 cells through an arbitrated port, then evaluates all 8 lines.
// Optional macro BOARD_SCANNER_WINLINE_EN adds the registered win_line[7:0] output.
module board_scanner (
    input  logic       ph1,
    input  logic       reset_n,
    input  logic       start,
    output logic       rd_req,
    input  logic       rd_gnt,
    output logic [3:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic       gameIsDone
`ifdef BOARD_SCANNER_WINLINE_EN
    ,
    output logic [7:0] win_line
`endif
);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, EVAL, DONE} state_t;

    // Cell addresses of each line, line 0 in the low 12 bits, cell k at bits [4k +: 4].
    localparam logic [95:0] LINES = {
        {4'd6, 4'd4, 4'd2},
        {4'd8, 4'd4, 4'd0},
        {4'd8, 4'd5, 4'd2},
        {4'd7, 4'd4, 4'd1},
        {4'd6, 4'd3, 4'd0},
        {4'd8, 4'd7, 4'd6},
        {4'd5, 4'd4, 4'd3},
        {4'd2, 4'd1, 4'd0}
    };

    state_t     state_reg;
    logic [3:0] cnt_reg;
    logic       pending_reg;
    logic       cap_valid_reg;
    logic [3:0] cap_addr_reg;
    logic [1:0] shadow_reg [0:8];
    logic       rd_req_reg;
    logic [3:0] rd_addr_reg;
    logic       busy_reg;
    logic       done_reg;
    logic [1:0] result_reg;
    logic       game_done_reg;
    logic [7:0] win_line_reg;

    logic [7:0] p1_lines;
    logic [7:0] p2_lines;
    logic [8:0] filled;
    logic [1:0] eval_result;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_line
            assign p1_lines[gi] = (shadow_reg[LINES[gi*12 +: 4]] == 2'b11)
                               && (shadow_reg[LINES[gi*12+4 +: 4]] == 2'b11)
                               && (shadow_reg[LINES[gi*12+8 +: 4]] == 2'b11);
            assign p2_lines[gi] = (shadow_reg[LINES[gi*12 +: 4]] == 2'b10)
                               && (shadow_reg[LINES[gi*12+4 +: 4]] == 2'b10)
                               && (shadow_reg[LINES[gi*12+8 +: 4]] == 2'b10);
        end
        for (gi = 0; gi < 9; gi++) begin : g_fill
            assign filled[gi] = (shadow_reg[gi] != 2'b00);
        end
    endgenerate

    assign eval_result = (|p1_lines) ? 2'b11 :
                         (|p2_lines) ? 2'b10 :
                         (&filled)   ? 2'b01 : 2'b00;

    always_ff @(posedge ph1) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            pending_reg   <= 1'b0;
            cap_valid_reg <= 1'b0;
            cap_addr_reg  <= 4'd0;
            rd_req_reg    <= 1'b0;
            rd_addr_reg   <= 4'hF;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= 2'b00;
            game_done_reg <= 1'b0;
            win_line_reg  <= 8'd0;
            for (int i = 0; i < 9; i++) begin
                shadow_reg[i] <= 2'b00;
            end
        end else begin
            done_reg      <= 1'b0;
            cap_valid_reg <= 1'b0;
            // Read data arrives one cycle after the grant; code 01 is folded to empty here.
            if (cap_valid_reg) begin
                shadow_reg[cap_addr_reg] <= (rd_data == 2'b01) ? 2'b00 : rd_data;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= SCAN;
                        cnt_reg     <= 4'd0;
                        rd_req_reg  <= 1'b1;
                        rd_addr_reg <= 4'd0;
                        busy_reg    <= 1'b1;
                    end
                end
                SCAN: begin
                    if (start) pending_reg <= 1'b1;
                    if (rd_gnt) begin
                        cap_valid_reg <= 1'b1;
                        cap_addr_reg  <= cnt_reg;
                        if (cnt_reg == 4'd8) begin
                            state_reg   <= DRAIN;
                            rd_req_reg  <= 1'b0;
                            rd_addr_reg <= 4'hF;
                        end else begin
                            cnt_reg     <= cnt_reg + 4'd1;
                            rd_addr_reg <= cnt_reg + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (start) pending_reg <= 1'b1;
                    state_reg <= EVAL;
                end
                EVAL: begin
                    if (start) pending_reg <= 1'b1;
                    result_reg    <= eval_result;
                    game_done_reg <= (eval_result != 2'b00);
                    win_line_reg  <= p1_lines | p2_lines;
                    done_reg      <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    // A start arriving in this very cycle counts as pending and is served at once.
                    if (pending_reg || start) begin
                        pending_reg <= 1'b0;
                        state_reg   <= SCAN;
                        cnt_reg     <= 4'd0;
                        rd_req_reg  <= 1'b1;
                        rd_addr_reg <= 4'd0;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    rd_req_reg  <= 1'b0;
                    rd_addr_reg <= 4'hF;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign rd_req     = rd_req_reg;
    assign rd_addr    = rd_addr_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign result     = result_reg;
    assign gameIsDone = game_done_reg;
`ifdef BOARD_SCANNER_WINLINE_EN
    assign win_line   = win_line_reg;
`else
    logic unused_win_line;
    assign unused_win_line = ^win_line_reg;
`endif

endmodule

// File: tb/tb_board_scanner.sv
// Randomized self-checking bench for board_scanner against a line-table reference model.
module tb_board_scanner;

    logic       ph1 = 1'b0;
    logic       reset_n;
    logic       start;
    logic       rd_req;
    logic       rd_gnt;
    logic [3:0] rd_addr;
    logic [1:0] rd_data;
    logic       busy;
    logic       done;
    logic [1:0] result;
    logic       gameIsDone;
`ifdef BOARD_SCANNER_WINLINE_EN
    logic [7:0] win_line;
`endif

    board_scanner dut (
        .ph1        (ph1),
        .reset_n    (reset_n),
        .start      (start),
        .rd_req     (rd_req),
        .rd_gnt     (rd_gnt),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .gameIsDone (gameIsDone)
`ifdef BOARD_SCANNER_WINLINE_EN
        ,
        .win_line   (win_line)
`endif
    );

    always #5 ph1 = ~ph1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] board [9];
    logic [1:0] last_res = 2'b00;
    int line_tab [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                            '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: count each player's marks per line, then apply the result priority.
    function automatic void model(output logic [1:0] res, output logic [7:0] wl);
        bit p1 = 0;
        bit p2 = 0;
        int empties = 0;
        wl = 8'd0;
        for (int l = 0; l < 8; l++) begin
            int o = 0;
            int x = 0;
            for (int k = 0; k < 3; k++) begin
                if (board[line_tab[l][k]] == 2'b11) o++;
                if (board[line_tab[l][k]] == 2'b10) x++;
            end
            if (o == 3) begin wl[l] = 1'b1; p1 = 1; end
            if (x == 3) begin wl[l] = 1'b1; p2 = 1; end
        end
        for (int c = 0; c < 9; c++) if (board[c] == 2'b00 || board[c] == 2'b01) empties++;
        res = p1 ? 2'b11 : p2 ? 2'b10 : (empties == 0) ? 2'b01 : 2'b00;
    endfunction

    task automatic random_board();
        for (int c = 0; c < 9; c++) board[c] = 2'($urandom_range(3));
        if ($urandom_range(99) < 40) begin
            int l = $urandom_range(7);
            logic [1:0] p = ($urandom_range(1) != 0) ? 2'b11 : 2'b10;
            for (int k = 0; k < 3; k++) board[line_tab[l][k]] = p;
        end
    endtask

    task automatic set_board(input logic [17:0] cells);
        for (int c = 0; c < 9; c++) board[c] = cells[17-2*c -: 2];
    endtask

    // Runs one scan from cycle 0 (or cycle 1 when already restarted) to its done cycle.
    task automatic scan_once(input bit issue_start, input int deny_pct, input int deny_addr,
                             input int deny_n, input logic [63:0] start_mask,
                             input int start_pct, output bit restart);
        int cyc = 1;
        int exp_addr = 0;
        int denies = 0;
        int deny_left = deny_n;
        int prev_addr = 0;
        bit prev_gnt = 0;
        bit done_seen = 0;
        bit g;
        bit st;
        logic [1:0] exp_res;
        logic [7:0] exp_wl;
        restart = 0;
        model(exp_res, exp_wl);
        if (issue_start) begin
            start = 1'b1;
            rd_gnt = 1'b0;
            @(negedge ph1);
        end
        start = 1'b0;
        while (!done_seen && cyc < 100) begin
            rd_data = prev_gnt ? board[prev_addr] : 2'($urandom);
            check("busy", busy, 1);
            if (exp_addr <= 8) begin
                check("rd_addr", {rd_req, rd_addr}, {1'b1, 4'(exp_addr)});
                if (exp_addr == deny_addr && deny_left > 0) begin
                    g = 0;
                    deny_left--;
                end else begin
                    g = ($urandom_range(99) >= deny_pct);
                end
                rd_gnt = g;
                prev_gnt = g;
                prev_addr = exp_addr;
                if (g) exp_addr++; else denies++;
            end else begin
                check("rd_idle", {rd_req, rd_addr}, 5'h0F);
                rd_gnt = 1'b0;
                prev_gnt = 0;
            end
            st = ((cyc < 64) && start_mask[cyc]) || ($urandom_range(99) < start_pct);
            start = st;
            if (st) restart = 1;
            if (done) begin
                done_seen = 1;
                check("done_cycle", cyc, 12 + denies);
                check("result", result, exp_res);
                check("gameIsDone", gameIsDone, exp_res != 2'b00);
`ifdef BOARD_SCANNER_WINLINE_EN
                check("win_line", win_line, exp_wl);
`endif
                last_res = exp_res;
                $display("scan: done at cycle %0d, denies %0d, result %b (model %b), win_line model %b",
                         cyc, denies, result, exp_res, exp_wl);
            end else begin
                check("result_hold", {result, gameIsDone}, {last_res, last_res != 2'b00});
                @(negedge ph1);
                cyc++;
            end
        end
        check("done_seen", done_seen, 1);
    endtask

    task automatic run_chain(input int deny_pct, input int deny_addr, input int deny_n,
                             input logic [63:0] start_mask, input int start_pct);
        bit restart;
        int n = 0;
        scan_once(1, deny_pct, deny_addr, deny_n, start_mask, start_pct, restart);
        while (restart && n < 10) begin
            @(negedge ph1);
            start = 1'b0;
            random_board();
            scan_once(0, deny_pct, 15, 0, 64'd0, (n < 8) ? start_pct : 0, restart);
            n++;
        end
        @(negedge ph1);
        start = 1'b0;
        rd_gnt = 1'b0;
        check("idle_after", {done, busy, rd_req}, 3'b000);
    endtask

    initial begin
        int done_pulses;
        reset_n = 1'b0;
        start   = 1'b0;
        rd_gnt  = 1'b0;
        rd_data = 2'b00;
        repeat (3) @(negedge ph1);
        check("rst_outputs", {busy, done, rd_req, rd_addr, result, gameIsDone}, 10'b000_1111_000);
`ifdef BOARD_SCANNER_WINLINE_EN
        check("rst_win_line", win_line, 8'd0);
`endif
        reset_n = 1'b1;
        @(negedge ph1);

        set_board(18'b00_00_00_00_00_00_00_00_00);                 // empty board
        run_chain(0, 15, 0, 64'd0, 0);
        set_board(18'b11_10_10_00_11_00_10_00_11);                 // O diagonal 0,4,8
        run_chain(0, 15, 0, 64'd0, 0);
        set_board(18'b11_10_11_11_10_10_10_11_11);                 // full, no line: tie
        run_chain(0, 15, 0, 64'd0, 0);
        set_board(18'b00_10_00_11_10_11_00_10_00);                 // X column 1,4,7
        run_chain(0, 15, 0, 64'd0, 0);
        set_board(18'b11_10_01_00_11_10_10_00_11);                 // grant held off at cell 4
        run_chain(0, 4, 3, 64'd0, 0);
        set_board(18'b11_11_11_10_10_10_00_00_00);                 // both win; starts at 0,5,6
        run_chain(0, 15, 0, 64'h60, 0);

        for (int t = 0; t < 25; t++) begin
            random_board();
            run_chain($urandom_range(40), 15, 0, 64'd0, 2);
        end

        // Reset in the middle of a scan of a won board.
        set_board(18'b11_10_10_00_11_00_10_00_11);
        run_chain(0, 15, 0, 64'd0, 0);
        start = 1'b1;
        @(negedge ph1);
        start = 1'b0;
        rd_gnt = 1'b1;
        for (int c = 1; c < 6; c++) begin
            rd_data = 2'($urandom);
            @(negedge ph1);
        end
        reset_n = 1'b0;
        @(negedge ph1);
        check("midrst_outputs", {busy, done, rd_req, rd_addr, result, gameIsDone}, 10'b000_1111_000);
`ifdef BOARD_SCANNER_WINLINE_EN
        check("midrst_win_line", win_line, 8'd0);
`endif
        reset_n = 1'b1;
        rd_gnt = 1'b0;
        done_pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge ph1);
            if (done || busy) done_pulses++;
        end
        check("no_done_after_reset", done_pulses, 0);
        last_res = 2'b00;
        random_board();
        run_chain(10, 15, 0, 64'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
